// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer and the ALU result mux:
// sequencer state encodings and ALU op codes.
package alu_op_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;

endpackage

// File: rtl/alu_op_sequencer.sv
// Operand-loading and result-capture stage around the combinational 8-bit ALU.
// Two input beats (A with op select, then B) load the ALU operand registers.
// After one settle cycle the ALU output is captured with Z/N flags and held
// on the output port until the consumer takes it.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int OP_BITS = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   IN_DATA,
    input  logic [OP_BITS-1:0] IN_OP,
    output logic [WIDTH-1:0]   ALU_A,
    output logic [WIDTH-1:0]   ALU_B,
    output logic [OP_BITS-1:0] ALU_SEL,
    input  logic [WIDTH-1:0]   ALU_O,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic               FLAG_Z,
    output logic               FLAG_N
);

    seq_state_t state;
    seq_state_t state_next;
    logic       in_fire;

    assign in_fire = IN_VALID && IN_READY;

    // State register; reset discards any partial load or pending result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: two accepted beats, one settle cycle, hold until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (IN_VALID)  state_next = LOAD_B;
            LOAD_B:  if (IN_VALID)  state_next = EXEC;
            EXEC:                   state_next = HOLD;
            HOLD:    if (OUT_READY) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state, forced low while reset is asserted.
    always_comb begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        if (!RST) begin
            IN_READY  = (state == IDLE) || (state == LOAD_B);
            OUT_VALID = (state == HOLD);
        end
    end

    // Operand registers load on accepted beats and hold until overwritten;
    // the result and flags are captured at the end of the settle cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_SEL  <= '0;
            OUT_DATA <= '0;
            FLAG_Z   <= 1'b0;
            FLAG_N   <= 1'b0;
        end else begin
            if (in_fire && state == IDLE) begin
                ALU_A   <= IN_DATA;
                ALU_SEL <= IN_OP;
            end
            if (in_fire && state == LOAD_B) begin
                ALU_B <= IN_DATA;
            end
            if (state == EXEC) begin
                OUT_DATA <= ALU_O;
                FLAG_Z   <= (ALU_O == '0);
                FLAG_N   <= ALU_O[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU mux beside it.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int WIDTH   = 8;
    localparam int OP_BITS = 3;

    logic               CLK = 1'b0;
    logic               RST;
    logic               IN_VALID;
    logic               IN_READY;
    logic [WIDTH-1:0]   IN_DATA;
    logic [OP_BITS-1:0] IN_OP;
    logic [WIDTH-1:0]   ALU_A;
    logic [WIDTH-1:0]   ALU_B;
    logic [OP_BITS-1:0] ALU_SEL;
    logic [WIDTH-1:0]   ALU_O;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [WIDTH-1:0]   OUT_DATA;
    logic               FLAG_Z;
    logic               FLAG_N;

    int checks   = 0;
    int failures = 0;

    alu_op_sequencer #(.WIDTH(WIDTH), .OP_BITS(OP_BITS)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_OP(IN_OP),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SEL(ALU_SEL), .ALU_O(ALU_O),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .FLAG_Z(FLAG_Z), .FLAG_N(FLAG_N)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU sitting alongside the sequencer.
    always_comb begin
        ALU_O = '0;
        case (ALU_SEL)
            OP_AND:  ALU_O = ALU_A & ALU_B;
            OP_OR:   ALU_O = ALU_A | ALU_B;
            OP_XOR:  ALU_O = ALU_A ^ ALU_B;
            OP_NOT:  ALU_O = ~ALU_A;
            OP_ADD:  ALU_O = ALU_A + ALU_B;
            OP_SUB:  ALU_O = ALU_A - ALU_B;
            default: ALU_O = '0;
        endcase
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
        check({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic z, input logic n);
        check({tag, "_out_valid"}, 32'(OUT_VALID), 32'd1);
        check({tag, "_in_ready"}, 32'(IN_READY), 32'd0);
        check({tag, "_data"}, 32'(OUT_DATA), 32'(d));
        check({tag, "_z"}, 32'(FLAG_Z), 32'(z));
        check({tag, "_n"}, 32'(FLAG_N), 32'(n));
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; IN_OP = '0; OUT_READY = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(IN_READY), 32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_alu_a", 32'(ALU_A), 32'd0);
        check("rst_out_data", 32'(OUT_DATA), 32'd0);
        check("rst_flag_z", 32'(FLAG_Z), 32'd0);
        RST = 1'b0;
        #1;
        check_idle("post_rst");

        // AA & FF, consumer ready
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 8'hAA; IN_OP = OP_AND;
        tick();
        check("t1_alu_a", 32'(ALU_A), 32'hAA);
        check("t1_alu_sel", 32'(ALU_SEL), 32'(OP_AND));
        check("t1_loadb_ready", 32'(IN_READY), 32'd1);
        IN_DATA = 8'hFF;
        tick();
        check("t1_alu_b", 32'(ALU_B), 32'hFF);
        check("t1_exec_ready", 32'(IN_READY), 32'd0);
        check("t1_exec_valid", 32'(OUT_VALID), 32'd0);
        IN_VALID = 1'b0;
        tick();
        check_result("t1", 8'hAA, 1'b0, 1'b1);
        tick();
        check_idle("t1_back");

        // 00 & FF -> zero
        IN_VALID = 1'b1; IN_DATA = 8'h00; IN_OP = OP_AND;
        tick();
        IN_DATA = 8'hFF;
        tick();
        IN_VALID = 1'b0;
        tick();
        check_result("t2", 8'h00, 1'b1, 1'b0);
        tick();
        check_idle("t2_back");

        // FF & FF with consumer stalled for 3 cycles
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 8'hFF; IN_OP = OP_AND;
        tick();
        tick();
        IN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_result($sformatf("t3_hold%0d", i), 8'hFF, 1'b0, 1'b1);
        end
        OUT_READY = 1'b1;
        tick();
        check_idle("t3_back");

        // gap between beats, op changed on the B beat
        IN_VALID = 1'b1; IN_DATA = 8'h3C; IN_OP = OP_AND;
        tick();
        IN_VALID = 1'b0; IN_DATA = 8'h99; IN_OP = OP_OR;
        tick();
        tick();
        check("t4_gap_ready", 32'(IN_READY), 32'd1);
        check("t4_gap_alu_b", 32'(ALU_B), 32'hFF);
        IN_VALID = 1'b1; IN_DATA = 8'h0F;
        tick();
        check("t4_alu_b", 32'(ALU_B), 32'h0F);
        check("t4_alu_sel", 32'(ALU_SEL), 32'(OP_AND));
        IN_VALID = 1'b0;
        tick();
        check_result("t4", 8'h0C, 1'b0, 1'b0);
        tick();
        check_idle("t4_back");

        // reset while waiting for B
        IN_VALID = 1'b1; IN_DATA = 8'h55; IN_OP = OP_XOR;
        tick();
        check("t5_alu_a", 32'(ALU_A), 32'h55);
        IN_VALID = 1'b0; RST = 1'b1;
        tick();
        check("t5_rst_in_ready", 32'(IN_READY), 32'd0);
        check("t5_rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("t5_rst_alu_a", 32'(ALU_A), 32'd0);
        check("t5_rst_alu_b", 32'(ALU_B), 32'd0);
        check("t5_rst_alu_sel", 32'(ALU_SEL), 32'd0);
        check("t5_rst_out_data", 32'(OUT_DATA), 32'd0);
        check("t5_rst_flag_n", 32'(FLAG_N), 32'd0);
        RST = 1'b0;
        #1;
        check_idle("t5_after_rst");
        IN_VALID = 1'b1; IN_DATA = 8'h0F; IN_OP = OP_AND;
        tick();
        IN_DATA = 8'hF0;
        tick();
        IN_VALID = 1'b0;
        tick();
        check_result("t5", 8'h00, 1'b1, 1'b0);
        tick();
        check_idle("t5_back");

        // IN_VALID held high with 0x33 during EXEC and HOLD
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 8'h12; IN_OP = OP_AND;
        tick();
        IN_DATA = 8'h34;
        tick();
        IN_DATA = 8'h33; IN_OP = OP_OR;
        tick();
        check_result("t6_h0", 8'h10, 1'b0, 1'b0);
        check("t6_h0_alu_a", 32'(ALU_A), 32'h12);
        check("t6_h0_alu_b", 32'(ALU_B), 32'h34);
        tick();
        check_result("t6_h1", 8'h10, 1'b0, 1'b0);
        check("t6_h1_alu_a", 32'(ALU_A), 32'h12);
        OUT_READY = 1'b1;
        tick();
        check_idle("t6_back");
        check("t6_back_alu_a", 32'(ALU_A), 32'h12);
        tick();
        check("t6_new_alu_a", 32'(ALU_A), 32'h33);
        check("t6_new_alu_sel", 32'(ALU_SEL), 32'(OP_OR));
        check("t6_new_loadb", 32'(IN_READY), 32'd1);
        IN_VALID = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
